// File: rtl/ysyx_25060173_mem_arbiter_if.sv
// rtl/ysyx_25060173_mem_arbiter_if.sv - IFU/LSU/memory bus bundle for the memory arbiter
//
// Carries the IFU request/response, LSU request/response and the shared
// memory request/response channel.
//   slave  : the arbiter side (takes requests, answers requesters, drives memory)
//   master : the surrounding core and memory (requesters plus memory model)
interface ysyx_25060173_mem_arbiter_if;
    logic        ifu_req_valid;
    logic [31:0] ifu_req_addr;
    logic        ifu_req_ready;
    logic        ifu_resp_valid;
    logic [31:0] ifu_resp_data;
    logic        ifu_resp_err;

    logic        lsu_req_valid;
    logic [31:0] lsu_req_addr;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_wdata;
    logic [3:0]  lsu_req_wmask;
    logic        lsu_req_ready;
    logic        lsu_resp_valid;
    logic [31:0] lsu_resp_data;
    logic        lsu_resp_err;

    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        mem_resp_err;

    modport slave (
        input  ifu_req_valid, ifu_req_addr,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask
    );

    modport master (
        output ifu_req_valid, ifu_req_addr,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask
    );
endinterface

// File: rtl/ysyx_25060173_mem_arbiter.sv
// rtl/ysyx_25060173_mem_arbiter.sv - IFU/LSU arbiter sharing one memory port, with response watchdog
//
// Ports:
//   clk     : clock, all state on rising edge
//   reset_n : asynchronous active-low reset
//   bus     : ysyx_25060173_mem_arbiter_if.slave (IFU req/resp, LSU req/resp, memory channel)
// Parameters:
//   TIMEOUT_CYCLES : RESP cycles before the watchdog answers with an error (0 disables), 0..65535
// Configuration macro:
//   MEM_ARB_RR_EN  : defined -> round-robin between IFU and LSU; undefined -> LSU has fixed priority
module ysyx_25060173_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           reset_n,
    ysyx_25060173_mem_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    localparam logic        OWNER_IFU   = 1'b0;
    localparam logic        OWNER_LSU   = 1'b1;

    state_t      state_q, state_d;

    logic        owner_q;
    logic [31:0] addr_q;
    logic        wen_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;
    logic [15:0] wdog_q;

    logic        ifu_resp_valid_q, lsu_resp_valid_q;
    logic [31:0] ifu_resp_data_q,  lsu_resp_data_q;
    logic        ifu_resp_err_q,   lsu_resp_err_q;

    logic        lsu_wins;
    logic        grant_ifu, grant_lsu;
    logic        resp_take, wdog_fire;

`ifdef MEM_ARB_RR_EN
    // 1 = pointer at LSU. On contention the pointed requester wins.
    logic rr_ptr_q;
    assign lsu_wins = bus.lsu_req_valid & (~bus.ifu_req_valid | rr_ptr_q);
`else
    assign lsu_wins = bus.lsu_req_valid;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        resp_take = 1'b0;
        wdog_fire = 1'b0;
        case (state_q)
            S_IDLE: begin
                // reset_n gate keeps req_ready low while reset is held.
                if (reset_n && (bus.ifu_req_valid || bus.lsu_req_valid)) begin
                    grant_lsu = lsu_wins;
                    grant_ifu = ~lsu_wins;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                // A real response takes precedence over a timeout in the same cycle.
                if (bus.mem_resp_valid) begin
                    resp_take = 1'b1;
                    state_d   = S_IDLE;
                end else if ((TIMEOUT_LIM != 16'd0) && (wdog_q == TIMEOUT_LIM)) begin
                    wdog_fire = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.ifu_req_ready  = grant_ifu;
    assign bus.lsu_req_ready  = grant_lsu;

    assign bus.mem_req_valid  = (state_q == S_REQ);
    assign bus.mem_req_addr   = addr_q;
    assign bus.mem_req_wen    = wen_q;
    assign bus.mem_req_wdata  = wdata_q;
    assign bus.mem_req_wmask  = wmask_q;

    assign bus.ifu_resp_valid = ifu_resp_valid_q;
    assign bus.ifu_resp_data  = ifu_resp_data_q;
    assign bus.ifu_resp_err   = ifu_resp_err_q;
    assign bus.lsu_resp_valid = lsu_resp_valid_q;
    assign bus.lsu_resp_data  = lsu_resp_data_q;
    assign bus.lsu_resp_err   = lsu_resp_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q          <= OWNER_IFU;
            addr_q           <= 32'd0;
            wen_q            <= 1'b0;
            wdata_q          <= 32'd0;
            wmask_q          <= 4'd0;
            wdog_q           <= 16'd0;
            ifu_resp_valid_q <= 1'b0;
            ifu_resp_data_q  <= 32'd0;
            ifu_resp_err_q   <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            lsu_resp_data_q  <= 32'd0;
            lsu_resp_err_q   <= 1'b0;
        end else begin
            // Response outputs are only non-zero during their one-cycle pulse.
            ifu_resp_valid_q <= 1'b0;
            ifu_resp_data_q  <= 32'd0;
            ifu_resp_err_q   <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            lsu_resp_data_q  <= 32'd0;
            lsu_resp_err_q   <= 1'b0;

            // IFU is read-only: its requests always carry wen=0, wmask=0.
            if (grant_lsu) begin
                owner_q <= OWNER_LSU;
                addr_q  <= bus.lsu_req_addr;
                wen_q   <= bus.lsu_req_wen;
                wdata_q <= bus.lsu_req_wdata;
                wmask_q <= bus.lsu_req_wmask;
            end else if (grant_ifu) begin
                owner_q <= OWNER_IFU;
                addr_q  <= bus.ifu_req_addr;
                wen_q   <= 1'b0;
                wdata_q <= 32'd0;
                wmask_q <= 4'd0;
            end

            // Counter stops at the limit; with the watchdog disabled the limit
            // is 0, so it never leaves 0.
            if ((state_q == S_REQ) && bus.mem_req_ready) begin
                wdog_q <= 16'd0;
            end else if ((state_q == S_RESP) && !bus.mem_resp_valid && (wdog_q != TIMEOUT_LIM)) begin
                wdog_q <= wdog_q + 16'd1;
            end

            if (resp_take || wdog_fire) begin
                if (owner_q == OWNER_LSU) begin
                    lsu_resp_valid_q <= 1'b1;
                    lsu_resp_data_q  <= (resp_take && !wen_q) ? bus.mem_resp_data : 32'd0;
                    lsu_resp_err_q   <= resp_take ? bus.mem_resp_err : 1'b1;
                end else begin
                    ifu_resp_valid_q <= 1'b1;
                    ifu_resp_data_q  <= resp_take ? bus.mem_resp_data : 32'd0;
                    ifu_resp_err_q   <= resp_take ? bus.mem_resp_err : 1'b1;
                end
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= OWNER_LSU;
        end else if ((grant_lsu && rr_ptr_q) || (grant_ifu && !rr_ptr_q)) begin
            rr_ptr_q <= ~rr_ptr_q;
        end
    end
`endif

endmodule
